// File: rtl/nios_hex_ctrl.sv
// Avalon-MM multi-digit seven-segment controller: hex decode or raw segments per digit, blank, blink, global enable.
// Zero-wait-state slave, registered hex_out; define NIOS_HEX_BLINK_EN to build the blink counter and BLINK register.
module nios_hex_ctrl #(
   parameter int NUM_DIGITS = 6,
   parameter int BLINK_DIV  = 25000000,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [2:0]                address,
   input  logic                      chipselect,
   input  logic                      write_n,
   input  logic [31:0]               writedata,
   output logic [31:0]               readdata,
   output logic [7*NUM_DIGITS-1:0]   hex_out
);

   localparam int   N       = NUM_DIGITS;
   localparam logic OFF_BIT = (ACTIVE_LOW != 0);

   logic [4*N-1:0] r_data;
   logic [N-1:0]   r_raw_en;
   logic [N-1:0]   r_blank;
   logic [6:0]     r_raw [N];
   logic           r_enable;
   logic [7*N-1:0] r_hex;

   logic           w_wr;
   logic           w_phase;
   logic [N-1:0]   w_blink;
   logic [6:0]     w_seg;
   logic [7*N-1:0] w_hex_nxt;
   logic           w_unused_ok;

   assign w_wr        = chipselect & ~write_n;
   assign w_unused_ok = &{1'b0, writedata};

   function automatic logic [6:0] f_dec(input logic [3:0] n);
      case (n)
         4'h0: f_dec = 7'h3F;  4'h1: f_dec = 7'h06;
         4'h2: f_dec = 7'h5B;  4'h3: f_dec = 7'h4F;
         4'h4: f_dec = 7'h66;  4'h5: f_dec = 7'h6D;
         4'h6: f_dec = 7'h7D;  4'h7: f_dec = 7'h07;
         4'h8: f_dec = 7'h7F;  4'h9: f_dec = 7'h6F;
         4'hA: f_dec = 7'h77;  4'hB: f_dec = 7'h7C;
         4'hC: f_dec = 7'h39;  4'hD: f_dec = 7'h5E;
         4'hE: f_dec = 7'h79;  default: f_dec = 7'h71;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         r_data   <= '0;
         r_raw_en <= '0;
         r_blank  <= '0;
         r_enable <= 1'b1;
         for (int i = 0; i < N; i++) r_raw[i] <= '0;
      end else if (w_wr) begin
         if (address == 3'd0) r_data   <= writedata[4*N-1:0];
         if (address == 3'd1) r_raw_en <= writedata[N-1:0];
         if (address == 3'd2) r_blank  <= writedata[N-1:0];
         if (address == 3'd6) r_enable <= writedata[0];
         // RAW_LO carries digits 0..3, RAW_HI digits 4..7, one byte each
         for (int i = 0; i < N; i++)
            if ((address == 3'd4 && i < 4) || (address == 3'd5 && i >= 4))
               r_raw[i] <= writedata[8*(i%4) +: 7];
      end
   end

`ifdef NIOS_HEX_BLINK_EN
   localparam int CW = $clog2(BLINK_DIV);

   logic [CW-1:0] r_cnt;
   logic          r_phase;
   logic [N-1:0]  r_blink;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt   <= '0;
         r_phase <= 1'b0;
         r_blink <= '0;
      end else begin
         if (w_wr && address == 3'd3) r_blink <= writedata[N-1:0];
         // restart takes precedence over a wrap on the same edge
         if (w_wr && address == 3'd6 && writedata[2]) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
         end else if (r_cnt == CW'(BLINK_DIV - 1)) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
         end else begin
            r_cnt   <= r_cnt + 1'b1;
         end
      end
   end

   assign w_phase = r_phase;
   assign w_blink = r_blink;
`else
   assign w_phase = 1'b0;
   assign w_blink = '0;
`endif

   always_comb begin
      readdata = '0;
      case (address)
         3'd0: readdata[4*N-1:0] = r_data;
         3'd1: readdata[N-1:0]   = r_raw_en;
         3'd2: readdata[N-1:0]   = r_blank;
         3'd3: readdata[N-1:0]   = w_blink;
         3'd4: for (int i = 0; i < N; i++) if (i < 4)  readdata[8*(i%4) +: 7] = r_raw[i];
         3'd5: for (int i = 0; i < N; i++) if (i >= 4) readdata[8*(i%4) +: 7] = r_raw[i];
         3'd6: readdata[1:0]     = {w_phase, r_enable};
         default: readdata = '0;
      endcase
   end

   always_comb begin
      w_hex_nxt = '0;
      w_seg     = '0;
      for (int i = 0; i < N; i++) begin
         w_seg = r_raw_en[i] ? r_raw[i] : f_dec(r_data[4*i +: 4]);
         if (!r_enable || r_blank[i] || (w_blink[i] && w_phase)) w_seg = '0;
         w_hex_nxt[7*i +: 7] = OFF_BIT ? ~w_seg : w_seg;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) r_hex <= {(7*N){OFF_BIT}};
      else       r_hex <= w_hex_nxt;
   end

   assign hex_out = r_hex;

endmodule

// File: tb/tb_nios_hex_ctrl.sv
// Directed bench for nios_hex_ctrl with NUM_DIGITS=6, ACTIVE_LOW=1, BLINK_DIV=4.
module tb_nios_hex_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [41:0] hex_out;

   int n_cmp = 0;
   int n_err = 0;

   nios_hex_ctrl #(.NUM_DIGITS(6), .BLINK_DIV(4), .ACTIVE_LOW(1)) dut (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata), .hex_out(hex_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  addr;
      logic [31:0] wdata;
      logic [31:0] rmask;
      logic [31:0] rexp;
      logic [41:0] hexp;
   } vec_t;

   vec_t vecs [15];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Called at a negedge; write lands on the next posedge, returns at the following negedge.
   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   initial begin
      vecs[0]  = '{3'd0, 32'h00A5F3,    32'hFFFFFFFF, 32'h00A5F3,   {7'h40,7'h40,7'h08,7'h12,7'h0E,7'h30}};
      vecs[1]  = '{3'd4, 32'h00000049,  32'hFFFFFFFF, 32'h00000049, {7'h40,7'h40,7'h08,7'h12,7'h0E,7'h30}};
      vecs[2]  = '{3'd1, 32'h00000001,  32'hFFFFFFFF, 32'h00000001, {7'h40,7'h40,7'h08,7'h12,7'h0E,7'h36}};
      vecs[3]  = '{3'd2, 32'h00000001,  32'hFFFFFFFF, 32'h00000001, {7'h40,7'h40,7'h08,7'h12,7'h0E,7'h7F}};
      vecs[4]  = '{3'd6, 32'h00000000,  32'hFFFFFFFD, 32'h00000000, {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F}};
      vecs[5]  = '{3'd6, 32'h00000001,  32'hFFFFFFFD, 32'h00000001, {7'h40,7'h40,7'h08,7'h12,7'h0E,7'h7F}};
      vecs[6]  = '{3'd2, 32'h00000000,  32'hFFFFFFFF, 32'h00000000, {7'h40,7'h40,7'h08,7'h12,7'h0E,7'h36}};
      vecs[7]  = '{3'd1, 32'h00000000,  32'hFFFFFFFF, 32'h00000000, {7'h40,7'h40,7'h08,7'h12,7'h0E,7'h30}};
      vecs[8]  = '{3'd0, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'h00FFFFFF, {7'h0E,7'h0E,7'h0E,7'h0E,7'h0E,7'h0E}};
      vecs[9]  = '{3'd7, 32'h12345678,  32'hFFFFFFFF, 32'h00000000, {7'h0E,7'h0E,7'h0E,7'h0E,7'h0E,7'h0E}};
      vecs[10] = '{3'd5, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'h00007F7F, {7'h0E,7'h0E,7'h0E,7'h0E,7'h0E,7'h0E}};
      vecs[11] = '{3'd1, 32'h00000030,  32'hFFFFFFFF, 32'h00000030, {7'h00,7'h00,7'h0E,7'h0E,7'h0E,7'h0E}};
      vecs[12] = '{3'd1, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'h0000003F, {7'h00,7'h00,7'h7F,7'h7F,7'h7F,7'h36}};
      vecs[13] = '{3'd1, 32'h00000000,  32'hFFFFFFFF, 32'h00000000, {7'h0E,7'h0E,7'h0E,7'h0E,7'h0E,7'h0E}};
      vecs[14] = '{3'd0, 32'h00000000,  32'hFFFFFFFF, 32'h00000000, {7'h40,7'h40,7'h40,7'h40,7'h40,7'h40}};

      reset = 1'b1; address = 3'd0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;

      // reset, with a write attempted on the second reset edge
      @(negedge clk);
      chk("reset_hex", 64'(hex_out), 64'h3FF_FFFF_FFFF);
      chipselect = 1'b1; write_n = 1'b0; writedata = 32'h00111111;
      @(negedge clk);
      reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
      chk("reset_hex_2", 64'(hex_out), 64'h3FF_FFFF_FFFF);
      @(negedge clk);
      chk("first_edge_hex", 64'(hex_out), 64'({6{7'h40}}));
      chk("write_in_reset_dropped", 64'(readdata), 64'h0);
      address = 3'd6;
      #1;
      chk("ctrl_after_reset", 64'(readdata), 64'h1);
      @(negedge clk);

      for (int i = 0; i < 15; i++) begin
         wr(vecs[i].addr, vecs[i].wdata);
         chk($sformatf("vec%0d_read", i), 64'(readdata & vecs[i].rmask), 64'(vecs[i].rexp));
         @(negedge clk);
         chk($sformatf("vec%0d_hex", i), 64'(hex_out), 64'(vecs[i].hexp));
      end

      // write strobe without chipselect
      address = 3'd0; writedata = 32'h00123456; chipselect = 1'b0; write_n = 1'b0;
      @(negedge clk);
      write_n = 1'b1;
      chk("no_cs_write", 64'(readdata), 64'h0);
      @(negedge clk);

`ifdef NIOS_HEX_BLINK_EN
      wr(3'd3, 32'h2);
      chk("blink_read", 64'(readdata), 64'h2);
      wr(3'd6, 32'h5);                       // restart lands on edge E0
      for (int j = 1; j <= 12; j++) begin
         @(negedge clk);                     // just after edge Ej
         chk($sformatf("blink_d1_e%0d", j), 64'(hex_out[13:7]), (((j-1)/4) % 2) ? 64'h7F : 64'h40);
         chk($sformatf("blink_d0_e%0d", j), 64'(hex_out[6:0]), 64'h40);
         chk($sformatf("phase_e%0d", j), 64'(readdata[1]), 64'((j/4) % 2));
      end
      repeat (7) @(negedge clk);             // just after E19, next edge is a wrap
      wr(3'd6, 32'h5);
      chk("restart_on_wrap_phase", 64'(readdata[1:0]), 64'h1);
      @(negedge clk);
      chk("restart_on_wrap_hex", 64'(hex_out[13:7]), 64'h40);
      repeat (2) @(negedge clk);
      chk("restart_cnt_e23", 64'(readdata[1]), 64'h0);
      @(negedge clk);
      chk("restart_cnt_e24", 64'(readdata[1]), 64'h1);
      wr(3'd3, 32'h0);
      chk("blink_clear", 64'(readdata), 64'h0);
`else
      wr(3'd3, 32'h3F);
      chk("blink_read_off", 64'(readdata), 64'h0);
      wr(3'd6, 32'h5);
      chk("ctrl_restart_off", 64'(readdata), 64'h1);
      for (int j = 0; j < 100; j++) begin
         @(negedge clk);
         if (hex_out !== {6{7'h40}})
            chk($sformatf("no_blink_c%0d", j), 64'(hex_out), 64'({6{7'h40}}));
      end
      chk("no_blink_end", 64'(hex_out), 64'({6{7'h40}}));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/nios_hex_ctrl.md
# nios_hex_ctrl

Parametrised multi-digit seven-segment display controller on an Avalon-MM slave, the successor to the single-digit 7-bit HEX output port. One instance drives up to eight digits. Per digit it provides hex decoding or raw segment control, blanking and blinking, plus a global enable. It sits on the Nios II data master alongside the other PIO peripherals, with its segment outputs wired directly to the board HEX pins.

## Interface
Parameters:
- NUM_DIGITS, 6: number of digits driven; legal range 1..8.
- BLINK_DIV, 25000000: clk cycles per blink half-period; minimum 2.
- ACTIVE_LOW, 1: 1 means a segment pin is driven 0 to light it; 0 means driven 1 to light it.

Ports:
- clk  in  1  system clock; one clock; all logic on its rising edge.
- reset  in  1  reset is synchronous and active-high.
- address  in  3  word address of the register.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data; combinational, zero wait states.
- hex_out  out  7*NUM_DIGITS  segments; digit i occupies bits [7i+6:7i]; bit 0 = segment a … bit 6 = segment g.

## Operation
- A write occurs when chipselect=1 and write_n=0 at a rising edge. Only full-word writes are supported.
- Register bits at or above the NUM_DIGITS limit are not stored and read 0. Reads ignore chipselect.
- Register map:
  - 0 DATA: 4-bit hex nibble per digit, nibble i → digit i; reset 0.
  - 1 RAW_EN: bit i set selects raw segments for digit i; reset 0.
  - 2 BLANK: bit i set turns digit i off; reset 0.
  - 3 BLINK: bit i set blanks digit i while the blink phase is 1; reset 0.
  - 4 RAW_LO: bytes 0..3 hold raw segments [6:0] for digits 0..3; reset 0.
  - 5 RAW_HI: same layout for digits 4..7; reset 0.
  - 6 CTRL: bit0 ENABLE (R/W, reset 1); bit1 PHASE (read-only); bit2 RESTART (write-only, self-clearing, reads 0).
  - 7: reserved; reads 0, writes ignored.
- Segment values are held in logical form (1 = lit). When ACTIVE_LOW=1 the logical value is inverted at the output register.
- Per-digit priority, highest first:
  - ENABLE=0 → off.
  - BLANK → off.
  - BLINK and PHASE=1 → off.
  - RAW_EN → raw byte.
  - Otherwise → decoded nibble.
- Hex decode (logical, g..a): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
- Blink counter:
  - Counts 0..BLINK_DIV-1, then wraps to 0; PHASE toggles on each wrap.
  - Writing CTRL with bit2=1 clears the counter and PHASE to 0 on that edge. This restart wins over a coincident wrap.

## Timing
- Reset:
  - All registers take their reset values; counter and PHASE are 0.
  - hex_out is all-off: all 1s when ACTIVE_LOW=1, all 0s when ACTIVE_LOW=0.
- hex_out is registered. A write at edge k updates the register at edge k; hex_out reflects it at edge k+1.
- First edge after reset deasserts: every digit shows decoded "0", which is 7'h40 when ACTIVE_LOW=1.
- readdata reflects the register written at edge k in the cycle following edge k.
- A PHASE change at edge k is visible on hex_out at edge k+1.
- Reset asserted mid-blink or mid-write: reset wins on that edge, and the write is discarded.

## Configuration
- NIOS_HEX_BLINK_EN defined:
  - Blink counter, PHASE and the BLINK register are implemented as described.
- NIOS_HEX_BLINK_EN undefined:
  - No counter is built.
  - BLINK reads 0 and writes to it are ignored.
  - PHASE reads 0 and RESTART has no effect.
  - The blink priority level never applies.
  - All other behaviour is unchanged.

## Test plan
All scenarios use NUM_DIGITS=6 and ACTIVE_LOW=1.
- Reset: hold reset for 2 cycles → hex_out=42'h3FF_FFFF_FFFF. One edge after release, every digit=7'h40 and CTRL reads 0x1.
- Decode: write DATA=0x00A5F3 → digit0=7'h30, digit1=7'h0E, digit2=7'h12, digit3=7'h08, digit4=digit5=7'h40. DATA reads back 0x00A5F3.
- Raw and priority:
  - Write RAW_LO=0x49 and RAW_EN=0x1 → digit0=7'h36.
  - Then write BLANK=0x1 → digit0=7'h7F.
  - Then write CTRL=0x0 → all digits 7'h7F.
- Blink (BLINK_DIV=4, macro defined): write BLINK=0x2 → digit1 alternates between its decoded value and 7'h7F every 4 cycles. Writing CTRL=0x5 on a wrap edge → PHASE=0, and the counter restarts from 0.
- Ignored accesses:
  - Write with chipselect=0 → no register change.
  - Write to address 7 → no change; address 7 reads 0.
  - Write DATA=0xFFFFFFFF → reads back 0x00FFFFFF.
- Macro off: build without NIOS_HEX_BLINK_EN, write BLINK=0x3F → reads 0, and no digit blinks over 100 cycles.
